// File: rtl/qoi_stream_encoder.sv
// Streaming QOI-style pixel encoder: packed {r,g,b} pixels in, encoded byte stream out.
// Pixels are accepted in IDLE; each produces either a run update or a 1..5 byte
// chunk (optional RUN byte + op bytes) that is emitted one byte per out handshake.
module qoi_stream_encoder #(
    parameter int R_BITS     = 3,
    parameter int G_BITS     = 3,
    parameter int B_BITS     = 2,
    parameter int MAX_RUN    = 62,
    parameter int END_MARKER = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [R_BITS+G_BITS+B_BITS-1:0] in_pixel,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [7:0]                       out_byte,
    output logic                             out_last
);

    localparam int PIX_W = R_BITS + G_BITS + B_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_END  = 2'd2
    } state_t;

    // Index slot of a pixel; 6-bit arithmetic gives the mod-64 directly.
    function automatic logic [5:0] qoi_hash(input logic [23:0] px);
        return 6'(px[23:16]) * 6'd3 + 6'(px[15:8]) * 6'd5 + 6'(px[7:0]) * 6'd7 + 6'd53;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  chunk_q [5];
    logic [7:0]  chunk_d [5];
    logic [2:0]  len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic        ending_q, ending_d;
    logic [5:0]  run_q, run_d;
    logic [23:0] prev_q, prev_d;
    logic [63:0] valid_q, valid_d;
    logic [23:0] index_q [64];
    logic [23:0] index_d [64];
    logic [2:0]  end_cnt_q, end_cnt_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        in_ready_q, in_ready_d;

    logic [7:0]  r8_s, g8_s, b8_s;
    logic [23:0] px_s;
    logic [5:0]  hash_s;
    logic [5:0]  run_inc_s;
    logic [7:0]  dr_s, dg_s, db_s;
    logic [7:0]  dr2_s, dg2_s, db2_s, dg32_s, drg8_s, dbg8_s;
    logic [7:0]  op_s [4];
    logic [2:0]  op_len_s;
    logic        pix_acc_s, out_acc_s;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_last  = out_last_q;

    // Expand fields to 8 bits (left-aligned), hash and biased differences vs prev.
    always_comb begin
        r8_s      = 8'(in_pixel[PIX_W-1 -: R_BITS]) << (8 - R_BITS);
        g8_s      = 8'(in_pixel[G_BITS+B_BITS-1 -: G_BITS]) << (8 - G_BITS);
        b8_s      = 8'(in_pixel[B_BITS-1:0]) << (8 - B_BITS);
        px_s      = {r8_s, g8_s, b8_s};
        hash_s    = qoi_hash(px_s);
        run_inc_s = run_q + 6'd1;
        dr_s      = r8_s - prev_q[23:16];
        dg_s      = g8_s - prev_q[15:8];
        db_s      = b8_s - prev_q[7:0];
        // Biasing turns each signed range check into one unsigned compare.
        dr2_s     = dr_s + 8'd2;
        dg2_s     = dg_s + 8'd2;
        db2_s     = db_s + 8'd2;
        dg32_s    = dg_s + 8'd32;
        drg8_s    = dr_s - dg_s + 8'd8;
        dbg8_s    = db_s - dg_s + 8'd8;
    end

    // Pick the op for a pixel that differs from prev: INDEX, DIFF, LUMA, else RGB.
    always_comb begin
        op_s[0]  = 8'h00;
        op_s[1]  = 8'h00;
        op_s[2]  = 8'h00;
        op_s[3]  = 8'h00;
        op_len_s = 3'd1;
        if (valid_q[hash_s] && (index_q[hash_s] == px_s)) begin
            op_s[0] = {2'b00, hash_s};
        end else if ((dr2_s < 8'd4) && (dg2_s < 8'd4) && (db2_s < 8'd4)) begin
            op_s[0] = {2'b01, dr2_s[1:0], dg2_s[1:0], db2_s[1:0]};
        end else if ((dg32_s < 8'd64) && (drg8_s < 8'd16) && (dbg8_s < 8'd16)) begin
            op_s[0]  = {2'b10, dg32_s[5:0]};
            op_s[1]  = {drg8_s[3:0], dbg8_s[3:0]};
            op_len_s = 3'd2;
        end else begin
            op_s[0]  = 8'hFE;
            op_s[1]  = r8_s;
            op_s[2]  = g8_s;
            op_s[3]  = b8_s;
            op_len_s = 3'd4;
        end
    end

    // FSM next state, chunk loading, byte sequencing and encoder state updates.
    always_comb begin
        state_d     = state_q;
        chunk_d     = chunk_q;
        len_d       = len_q;
        idx_d       = idx_q;
        ending_d    = ending_q;
        run_d       = run_q;
        prev_d      = prev_q;
        valid_d     = valid_q;
        index_d     = index_q;
        end_cnt_d   = end_cnt_q;
        out_byte_d  = out_byte_q;
        out_last_d  = out_last_q;
        pix_acc_s   = in_valid && in_ready_q;
        out_acc_s   = out_valid_q && out_ready;

        case (state_q)
            S_IDLE: begin
                if (pix_acc_s) begin
                    prev_d          = px_s;
                    index_d[hash_s] = px_s;
                    valid_d[hash_s] = 1'b1;
                    ending_d        = in_last;
                    idx_d           = 3'd0;
                    if (px_s == prev_q) begin
                        if ((run_inc_s == 6'(MAX_RUN)) || in_last) begin
                            chunk_d[0] = {2'b11, run_inc_s - 6'd1};
                            len_d      = 3'd1;
                            run_d      = 6'd0;
                            state_d    = S_EMIT;
                        end else begin
                            run_d = run_inc_s;
                        end
                    end else begin
                        // A pending run is flushed ahead of this pixel's op.
                        if (run_q != 6'd0) begin
                            chunk_d[0] = {2'b11, run_q - 6'd1};
                            chunk_d[1] = op_s[0];
                            chunk_d[2] = op_s[1];
                            chunk_d[3] = op_s[2];
                            chunk_d[4] = op_s[3];
                            len_d      = op_len_s + 3'd1;
                        end else begin
                            chunk_d[0] = op_s[0];
                            chunk_d[1] = op_s[1];
                            chunk_d[2] = op_s[2];
                            chunk_d[3] = op_s[3];
                            chunk_d[4] = 8'h00;
                            len_d      = op_len_s;
                        end
                        run_d   = 6'd0;
                        state_d = S_EMIT;
                    end
                    out_byte_d = chunk_d[0];
                    out_last_d = in_last && (END_MARKER == 0) && (len_d == 3'd1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT: begin
                if (out_acc_s) begin
                    if ((idx_q + 3'd1) < len_q) begin
                        idx_d      = idx_q + 3'd1;
                        out_byte_d = chunk_q[idx_d];
                        out_last_d = ending_q && (END_MARKER == 0) && ((idx_q + 3'd2) == len_q);
                    end else if (ending_q && (END_MARKER != 0)) begin
                        state_d    = S_END;
                        end_cnt_d  = 3'd0;
                        out_byte_d = 8'h00;
                        out_last_d = 1'b0;
                    end else if (ending_q) begin
                        // Frame done without marker: start the next frame clean.
                        state_d  = S_IDLE;
                        prev_d   = 24'h000000;
                        run_d    = 6'd0;
                        valid_d  = 64'h0;
                        ending_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_END: begin
                if (out_acc_s) begin
                    if (end_cnt_q == 3'd7) begin
                        state_d  = S_IDLE;
                        prev_d   = 24'h000000;
                        run_d    = 6'd0;
                        valid_d  = 64'h0;
                        ending_d = 1'b0;
                    end else begin
                        end_cnt_d  = end_cnt_q + 3'd1;
                        out_byte_d = (end_cnt_d == 3'd7) ? 8'h01 : 8'h00;
                        out_last_d = (end_cnt_d == 3'd7);
                    end
                end else begin
                    state_d = S_END;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_valid_d = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_IDLE);
        out_last_d  = out_last_d && (state_d != S_IDLE);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= 3'd0;
            idx_q       <= 3'd0;
            ending_q    <= 1'b0;
            run_q       <= 6'd0;
            prev_q      <= 24'h000000;
            valid_q     <= 64'h0;
            end_cnt_q   <= 3'd0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            ending_q    <= ending_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            valid_q     <= valid_d;
            end_cnt_q   <= end_cnt_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Data-only storage: index entries are qualified by valid_q, chunk by len_q.
    always_ff @(posedge clk) begin
        chunk_q <= chunk_d;
        index_q <= index_d;
    end

endmodule

// File: tb/tb_qoi_stream_encoder.sv
// Self-checking bench: one default-parameter encoder (a_*) and one 8:8:8 encoder (b_*).
// Expected bytes are queued per scenario and compared when the encoder hands them out.
module tb_qoi_stream_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;

    logic        a_in_valid = 1'b0, a_in_ready, a_in_last = 1'b0;
    logic [7:0]  a_in_pixel = 8'h00;
    logic        a_out_valid, a_out_ready = 1'b1, a_out_last;
    logic [7:0]  a_out_byte;

    logic        b_in_valid = 1'b0, b_in_ready, b_in_last = 1'b0;
    logic [23:0] b_in_pixel = 24'h0;
    logic        b_out_valid, b_out_ready = 1'b1, b_out_last;
    logic [7:0]  b_out_byte;

    logic [8:0]  qa[$];
    logic [8:0]  qb[$];
    logic [8:0]  ea, eb, a_hold_v, b_hold_v;
    logic        a_hold = 1'b0, b_hold = 1'b0;
    logic        rnd_b = 1'b0;

    qoi_stream_encoder dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pixel(a_in_pixel), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_byte(a_out_byte), .out_last(a_out_last)
    );

    qoi_stream_encoder #(.R_BITS(8), .G_BITS(8), .B_BITS(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pixel(b_in_pixel), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_byte(b_out_byte), .out_last(b_out_last)
    );

    always #5 clk = ~clk;

    // Random backpressure on encoder b when enabled.
    always @(posedge clk) begin
        if (rnd_b) begin
            #1;
            b_out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            if (a_hold && a_out_valid) begin
                total++;
                if ({a_out_last, a_out_byte} !== a_hold_v) begin
                    bad++;
                    $display("FAIL a_stall_stable got=%h exp=%h", {a_out_last, a_out_byte}, a_hold_v);
                end
            end
            if (b_hold && b_out_valid) begin
                total++;
                if ({b_out_last, b_out_byte} !== b_hold_v) begin
                    bad++;
                    $display("FAIL b_stall_stable got=%h exp=%h", {b_out_last, b_out_byte}, b_hold_v);
                end
            end
            a_hold   = a_out_valid && !a_out_ready;
            a_hold_v = {a_out_last, a_out_byte};
            b_hold   = b_out_valid && !b_out_ready;
            b_hold_v = {b_out_last, b_out_byte};
            if (a_out_valid && a_out_ready) begin
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL a_unexpected_byte got=%h exp=none", {a_out_last, a_out_byte});
                end else begin
                    ea = qa.pop_front();
                    if ({a_out_last, a_out_byte} !== ea) begin
                        bad++;
                        $display("FAIL a_byte got={last,byte}=%h exp=%h", {a_out_last, a_out_byte}, ea);
                    end
                end
            end
            if (b_out_valid && b_out_ready) begin
                total++;
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL b_unexpected_byte got=%h exp=none", {b_out_last, b_out_byte});
                end else begin
                    eb = qb.pop_front();
                    if ({b_out_last, b_out_byte} !== eb) begin
                        bad++;
                        $display("FAIL b_byte got={last,byte}=%h exp=%h", {b_out_last, b_out_byte}, eb);
                    end
                end
            end
        end
    end

    task automatic push_a(input logic [7:0] v, input logic last);
        qa.push_back({last, v});
    endtask

    task automatic push_b(input logic [7:0] v, input logic last);
        qb.push_back({last, v});
    endtask

    task automatic marker_a();
        for (int i = 0; i < 7; i++) push_a(8'h00, 1'b0);
        push_a(8'h01, 1'b1);
    endtask

    task automatic marker_b();
        for (int i = 0; i < 7; i++) push_b(8'h00, 1'b0);
        push_b(8'h01, 1'b1);
    endtask

    // Present a pixel to encoder a until accepted; returns 1 ns after the accepting edge.
    task automatic send_a(input logic [7:0] px, input logic last);
        int n = 0;
        a_in_valid = 1'b1; a_in_pixel = px; a_in_last = last;
        @(negedge clk);
        while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL a_send_timeout got=in_ready_low exp=accept");
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic send_b(input logic [23:0] px, input logic last);
        int n = 0;
        b_in_valid = 1'b1; b_in_pixel = px; b_in_last = last;
        @(negedge clk);
        while (!b_in_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL b_send_timeout got=in_ready_low exp=accept");
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    task automatic drain_a(input string name);
        int n = 0;
        while ((qa.size() != 0 || a_out_valid) && n < 2000) begin @(negedge clk); #1; n++; end
        total++;
        if (qa.size() != 0 || a_out_valid) begin
            bad++;
            $display("FAIL %s_drain got=left=%0d exp=left=0", name, qa.size());
            qa.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic drain_b(input string name);
        int n = 0;
        while ((qb.size() != 0 || b_out_valid) && n < 4000) begin @(negedge clk); #1; n++; end
        total++;
        if (qb.size() != 0 || b_out_valid) begin
            bad++;
            $display("FAIL %s_drain got=left=%0d exp=left=0", name, qb.size());
            qb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_out_valid, a_in_ready, a_out_last, a_out_byte} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_a got=%b exp=%b", {a_out_valid, a_in_ready, a_out_last, a_out_byte},
                     {1'b0, 1'b1, 1'b0, 8'h00});
        end
        total++;
        if ({b_out_valid, b_in_ready, b_out_last, b_out_byte} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_b got=%b exp=%b", {b_out_valid, b_in_ready, b_out_last, b_out_byte},
                     {1'b0, 1'b1, 1'b0, 8'h00});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Three identical zero pixels: one RUN byte then the end marker.
    task automatic test_run_end();
        push_a(8'hC2, 1'b0);
        marker_a();
        send_a(8'h00, 1'b0);
        send_a(8'h00, 1'b0);
        send_a(8'h00, 1'b1);
        drain_a("run_end");
    endtask

    // RGB op; in_ready stays low across exactly the 4 chunk handshakes, and a pixel
    // held during that window waits instead of being consumed.
    task automatic test_rgb_ready();
        int hs = 0;
        int n = 0;
        push_a(8'hFE, 1'b0); push_a(8'h20, 1'b0); push_a(8'h00, 1'b0); push_a(8'h00, 1'b0);
        push_a(8'hC0, 1'b0);
        marker_a();
        send_a(8'h20, 1'b0);
        total++;
        if (a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rgb_in_ready_low got=%b exp=0", a_in_ready);
        end
        a_in_valid = 1'b1; a_in_pixel = 8'h20; a_in_last = 1'b1;
        while (!a_in_ready && n < 100) begin
            @(negedge clk);
            if (a_out_valid && a_out_ready && !a_in_ready) hs++;
            n++;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_last = 1'b0;
        total++;
        if (hs != 4) begin
            bad++;
            $display("FAIL rgb_busy_handshakes got=%0d exp=4", hs);
        end
        drain_a("rgb_ready");
    endtask

    // DIFF then LUMA on the 8:8:8 encoder.
    task automatic test_diff_luma();
        push_b(8'h7E, 1'b0); push_b(8'hA8, 1'b0); push_b(8'hA6, 1'b0); push_b(8'hC0, 1'b0);
        marker_b();
        send_b(24'h010100, 1'b0);
        send_b(24'h0B0906, 1'b0);
        send_b(24'h0B0906, 1'b1);
        drain_b("diff_luma");
    endtask

    // INDEX hit on a previously seen colour, which also ends the frame.
    task automatic test_index();
        push_b(8'hFE, 1'b0); push_b(8'h20, 1'b0); push_b(8'h00, 1'b0); push_b(8'h00, 1'b0);
        push_b(8'hFE, 1'b0); push_b(8'h40, 1'b0); push_b(8'h00, 1'b0); push_b(8'h00, 1'b0);
        push_b(8'h15, 1'b0);
        marker_b();
        send_b(24'h200000, 1'b0);
        send_b(24'h400000, 1'b0);
        send_b(24'h200000, 1'b1);
        drain_b("index");
    endtask

    // Run saturates at 62, then a 1-long run on the last pixel.
    task automatic test_max_run();
        push_a(8'hFD, 1'b0); push_a(8'hC0, 1'b0);
        marker_a();
        for (int i = 0; i < 62; i++) send_a(8'h00, 1'b0);
        send_a(8'h00, 1'b1);
        drain_a("max_run");
    endtask

    // Mixed ops under random out_ready: RGB, DIFF, run, run flush + INDEX (wins over DIFF), run-last.
    task automatic test_backpressure();
        rnd_b = 1'b1;
        push_b(8'hFE, 1'b0); push_b(8'h10, 1'b0); push_b(8'h20, 1'b0); push_b(8'h30, 1'b0);
        push_b(8'h7F, 1'b0);
        push_b(8'hC1, 1'b0); push_b(8'h15, 1'b0);
        push_b(8'hC0, 1'b0);
        marker_b();
        send_b(24'h102030, 1'b0);
        send_b(24'h112131, 1'b0);
        send_b(24'h112131, 1'b0);
        send_b(24'h112131, 1'b0);
        send_b(24'h102030, 1'b0);
        send_b(24'h102030, 1'b1);
        drain_b("backpressure");
        rnd_b = 1'b0;
        @(posedge clk); #2;
        b_out_ready = 1'b1;
    endtask

    // Stall mid-chunk, then reset mid-chunk: remaining bytes dropped, frame state cleared.
    task automatic test_stall_reset();
        a_out_ready = 1'b0;
        push_a(8'hFE, 1'b0);
        send_a(8'h20, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({a_out_valid, a_out_byte} !== {1'b1, 8'hFE}) begin
                bad++;
                $display("FAIL stall_hold got=%h exp=%h", {a_out_valid, a_out_byte}, {1'b1, 8'hFE});
            end
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({a_out_valid, a_out_byte} !== {1'b1, 8'h20}) begin
            bad++;
            $display("FAIL stall_second_byte got=%h exp=%h", {a_out_valid, a_out_byte}, {1'b1, 8'h20});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({a_out_valid, a_in_ready, qa.size() == 0} !== 3'b011) begin
            bad++;
            $display("FAIL reset_mid_chunk got=%b exp=011", {a_out_valid, a_in_ready, qa.size() == 0});
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        push_a(8'hC0, 1'b0);
        marker_a();
        send_a(8'h00, 1'b1);
        drain_a("after_reset");
    endtask

    initial begin
        test_reset();
        test_run_end();
        test_rgb_ready();
        test_diff_luma();
        test_index();
        test_max_run();
        test_backpressure();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qoi_stream_encoder.md
QOI_STREAM_ENCODER -- requirements
Module: qoi_stream_encoder

Interface
REQ-001 SHALL have parameter R_BITS, default 3: red field width in in_pixel, legal range 1..8.
REQ-002 SHALL have parameter G_BITS, default 3: green field width, legal range 1..8.
REQ-003 SHALL have parameter B_BITS, default 2: blue field width, legal range 1..8.
REQ-004 SHALL have parameter MAX_RUN, default 62: longest run per RUN op, legal range 1..62.
REQ-005 SHALL have parameter END_MARKER, default 1: 1 = append the 8-byte end marker after the last pixel.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  in_pixel is valid.
REQ-009 in_ready  output  1  encoder accepts a pixel this cycle.
REQ-010 in_pixel  input  PIX_W=R_BITS+G_BITS+B_BITS  packed {r,g,b}, r in MSBs.
REQ-011 in_last  input  1  the pixel is the frame's final pixel.
REQ-012 out_valid  output  1  out_byte is valid.
REQ-013 out_ready  input  1  sink accepts out_byte.
REQ-014 out_byte  output  8  encoded stream byte.
REQ-015 out_last  output  1  final byte of the frame.

Function
REQ-016 SHALL expand each field to 8 bits by left-aligning it and zero-filling the LSBs.
REQ-017 SHALL accept a pixel on in_valid && in_ready; SHALL accept a byte on out_valid && out_ready.
REQ-018 SHALL run an FSM with states IDLE, EMIT and END.
REQ-019 In IDLE: in_ready=1 and out_valid=0; an accepted pixel either only updates run state (stay in IDLE) or loads a chunk buffer (go to EMIT).
REQ-020 The chunk buffer SHALL hold 1..5 bytes: an optional pending RUN byte followed by the pixel op bytes.
REQ-021 In EMIT: in_ready=0; bytes SHALL be output in buffer order, one per out handshake; after the last byte go to END if the frame is ending, else IDLE.
REQ-022 The first chunk byte SHALL have out_valid=1 in the cycle after pixel acceptance.
REQ-023 out_byte and out_last SHALL hold stable while out_valid && !out_ready.
REQ-024 Op priority SHALL be: (1) RUN, when px == prev.
REQ-025 RUN handling: run++; when run reaches MAX_RUN, emit 0xC0|(run-1) and clear run.
REQ-026 When px != prev and run>0, SHALL emit the RUN byte 0xC0|(run-1) first and clear run.
REQ-027 Op priority (2), INDEX: valid[h] && index[h]==px, where h=(r*3+g*5+b*7+53) mod 64; emit 0x00|h.
REQ-028 Op priority (3), DIFF: dr, dg, db each in -2..1; emit 0x40|(dr+2)<<4|(dg+2)<<2|(db+2).
REQ-029 Op priority (4), LUMA: dg in -32..31 and dr-dg, db-dg each in -8..7; emit 0x80|(dg+32), then (dr-dg+8)<<4|(db-dg+8).
REQ-030 Op priority (5), RGB: emit 0xFE, r, g, b.
REQ-031 Differences SHALL be 8-bit modulo-256, interpreted as signed two's complement.
REQ-032 For every accepted pixel, SHALL set prev=px, index[h]=px and valid[h]=1.
REQ-033 in_last handling: flush any pending run into the chunk; if the pixel itself is a run pixel, the chunk is the RUN byte alone.
REQ-034 END state: with END_MARKER=1, emit 00 00 00 00 00 00 00 01 with out_last on the final 0x01; with END_MARKER=0, out_last SHALL be asserted on the frame's last chunk byte instead.
REQ-035 After out_last is accepted: prev=(0,0,0), run=0, all valid bits cleared, return to IDLE, ready for the next frame.
REQ-036 A pixel presented while in_ready=0 SHALL NOT be consumed.

Reset
REQ-037 On rst: state=IDLE, in_ready=1, out_valid=0, out_last=0, out_byte=0x00, run=0, prev=(0,0,0), valid[63:0]=0.
REQ-038 Reset SHALL take priority over all activity; a mid-chunk or mid-marker reset discards the remaining bytes, and out_valid=0 from the next cycle.

Verification
REQ-039 Defaults: pixels 0x00, 0x00, 0x00 (last on third) -> C2 00 00 00 00 00 00 01, out_last only on 0x01.
REQ-040 Defaults: first pixel 0x20 (r=0x20), not last -> FE 20 00 00; in_ready low for exactly those 4 byte handshakes.
REQ-041 R/G/B_BITS=8: first pixel 0x010100 -> 7E; then 0x0B0906 -> A8 A6.
REQ-042 R/G/B_BITS=8: 0x200000, 0x400000, 0x200000 -> FE 20 00 00, FE 40 00 00, 15.
REQ-043 Defaults: 63 pixels 0x00, last on 63rd -> FD after the 62nd pixel, then C0 and end marker.
REQ-044 out_ready held low for 5 cycles mid-chunk, then rst asserted mid-chunk -> byte stable while stalled; after rst, out_valid=0 and in_ready=1.
